key_expansion_iter: RTL
=======================

KEY_EXPANSION_ITER -- requirements
Module: key_expansion_iter

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to expand key_in.
REQ-005 SHALL have port key_len, input, 2, key size select: 00 = AES-128 (Nk=4), 01 = AES-192 (Nk=6), 10 = AES-256 (Nk=8), 11 = illegal.
REQ-006 SHALL have port key_in, input, 256, cipher key, MSB-aligned; a 128-bit key occupies [255:128] and a 192-bit key occupies [255:64]; unused LSBs are ignored.
REQ-007 SHALL have port busy, output, 1, high while expansion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the last word is written.
REQ-009 SHALL have port err, output, 1, one-cycle pulse when a start is rejected.
REQ-010 SHALL have port rk_valid, output, 1, high while the stored schedule is complete and readable.
REQ-011 SHALL have port num_rounds, output, 4, Nr of the current schedule: 10, 12 or 14; 0 when rk_valid=0.
REQ-012 SHALL have port rk_rd_idx, input, 4, round-key index to read.
REQ-013 SHALL have port rk_rd_data, output, 128, round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.

Function
REQ-014 SHALL implement the FIPS-197 key expansion with Nr = Nk+6 and total words W = 4*(Nk+7), i.e. 44, 52 or 60 words.
REQ-015 SHALL store words in an internal array of 4*(MAX_NK+7) 32-bit entries.
REQ-016 SHALL use states IDLE, EXPAND and DONE; DONE is held until the next accepted start.
REQ-017 SHALL accept start only in IDLE or DONE, only when key_len is legal and its Nk <= MAX_NK.
REQ-018 On the accepting edge, SHALL write w[0..Nk-1] from key_in, latch Nk, clear rk_valid, set busy and enter EXPAND.
REQ-019 In EXPAND, SHALL write exactly one word w[i] per cycle for i = Nk..W-1, with w[i] = w[i-Nk] ^ t.
REQ-020 The term t SHALL be SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} when i mod Nk = 0; SubWord(w[i-1]) when Nk = 8 and i mod 8 = 4; otherwise w[i-1].
REQ-021 Rcon SHALL start at 8'h01 and advance by GF(2^8) xtime after each use, giving 01,02,04,08,10,20,40,80,1B,36.
REQ-022 SHALL complete expansion in W-Nk cycles after the accepting edge: 40, 46 or 52.
REQ-023 On the edge writing w[W-1], SHALL enter DONE, drop busy, set rk_valid, set num_rounds, and drive done high for exactly that following cycle.
REQ-024 SHALL ignore start while busy=1; there is no effect on state, done or err.
REQ-025 A rejected start (illegal key_len, or Nk > MAX_NK) SHALL pulse err for one cycle and leave state, busy, rk_valid and stored words unchanged.
REQ-026 rk_rd_data SHALL be registered, reflecting rk_rd_idx sampled on the previous edge, i.e. 1-cycle read latency.
REQ-027 rk_rd_data SHALL be 0 when rk_valid=0 or when rk_rd_idx > Nr.
REQ-028 A new accepted start in DONE SHALL restart expansion; rk_valid drops on that edge.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, err=0, rk_valid=0, num_rounds=0, rk_rd_data=0, Rcon=8'h01.
REQ-030 Reset mid-EXPAND SHALL abandon the expansion; the word array needs no reset because it is gated by rk_valid.

Verification
REQ-031 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done exactly 40 cycles after accept; idx 1 reads a0fafe1788542cb123a339392a6c7605; idx 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; num_rounds = 10.
REQ-032 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles; idx 12 reads e98ba06f448c773c8ecc720401002202; idx 13 reads 0.
REQ-033 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles; idx 14 reads fe4890d1e6188d0b046df344706c631e.
REQ-034 key_len=11 start, and key_len=10 start with MAX_NK=4 -> each gives a single err pulse; busy stays 0 and the prior schedule remains readable.
REQ-035 start pulsed while busy, then rst asserted at cycle 20 of EXPAND -> the extra start has no effect; after reset busy=0, rk_valid=0 and rk_rd_data=0; a subsequent AES-128 run matches REQ-031.

Source files
------------

// File: rtl/key_expansion_iter_if.sv
// Bus bundle for key_expansion_iter.
//   master: drives start, key_len, key_in, rk_rd_idx; observes status and read data.
//   slave : the expansion engine; drives busy, done, err, rk_valid, num_rounds, rk_rd_data.
interface key_expansion_iter_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic         rk_valid;
    logic [3:0]   num_rounds;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    modport master (
        output start, key_len, key_in, rk_rd_idx,
        input  busy, done, err, rk_valid, num_rounds, rk_rd_data
    );

    modport slave (
        input  start, key_len, key_in, rk_rd_idx,
        output busy, done, err, rk_valid, num_rounds, rk_rd_data
    );
endinterface

// File: rtl/key_expansion_iter.sv
// Iterative AES (FIPS-197) key expansion, one schedule word per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : key_expansion_iter_if.slave
//     start/key_len/key_in : request expansion of an MSB-aligned 128/192/256-bit key
//     busy/done/err        : expansion in progress / last word written / start rejected
//     rk_valid/num_rounds  : stored schedule complete, and its Nr (0 when invalid)
//     rk_rd_idx/rk_rd_data : registered round-key read port (1-cycle latency)
module key_expansion_iter #(
    parameter int unsigned MAX_NK = 8
) (
    input logic               clk,
    input logic               rst,
    key_expansion_iter_if.slave bus
);
    localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [3:0]  MAX_NK4 = 4'(MAX_NK);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    nk_q, nk_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    phase_q, phase_d;   // i mod Nk, tracked incrementally
    logic [7:0]    rcon_q, rcon_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rk_valid_q, rk_valid_d;
    logic [3:0]    num_rounds_q, num_rounds_d;
    logic [127:0]  rd_data_q, rd_data_d;

    logic [31:0]   w_mem [DEPTH];

    logic [7:0][31:0] key_words;
    logic [3:0]    nk_sel;
    logic          legal, accept, reject;
    logic [31:0]   w_prev, w_back, t_word, w_new;
    logic [AW-1:0] last_idx, rd_base;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, bb;
        p  = '0;
        x  = a;
        bb = b;
        for (int unsigned k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box computed as the affine map of the GF(2^8) inverse (x^254; 0 maps to 0).
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    assign key_words = bus.key_in;

    always_comb begin
        nk_sel = 4'd4 + {1'b0, bus.key_len, 1'b0};
        legal  = (bus.key_len != 2'b11) && (nk_sel <= MAX_NK4);
        accept = bus.start && (state_q != EXPAND) && legal;
        reject = bus.start && (state_q != EXPAND) && !legal;

        w_prev   = w_mem[idx_q - AW'(1)];
        w_back   = w_mem[idx_q - AW'(nk_q)];
        last_idx = AW'({nk_q, 2'b00}) + AW'(27);

        if (phase_q == 3'd0)
            t_word = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && phase_q == 3'd4)
            t_word = sub_word(w_prev);
        else
            t_word = w_prev;
        w_new = w_back ^ t_word;
    end

    always_comb begin
        state_d      = state_q;
        nk_d         = nk_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        rcon_d       = rcon_q;
        rk_valid_d   = rk_valid_q;
        num_rounds_d = num_rounds_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            EXPAND: begin
                if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
                if (idx_q == last_idx) begin
                    state_d      = DONE;
                    rk_valid_d   = 1'b1;
                    num_rounds_d = nk_q + 4'd6;
                    done_d       = 1'b1;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    phase_d = ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
                end
            end
            default: begin
                if (accept) begin
                    state_d      = EXPAND;
                    nk_d         = nk_sel;
                    idx_d        = AW'(nk_sel);
                    phase_d      = 3'd0;
                    rcon_d       = 8'h01;
                    rk_valid_d   = 1'b0;
                    num_rounds_d = 4'd0;
                end else if (reject) begin
                    err_d = 1'b1;
                end
            end
        endcase
    end

    // Gating on rk_valid_d as well blanks the port on the same edge a restart drops rk_valid.
    always_comb begin
        rd_base   = AW'({bus.rk_rd_idx, 2'b00});
        rd_data_d = '0;
        if (rk_valid_q && rk_valid_d && bus.rk_rd_idx <= num_rounds_q)
            rd_data_d = {w_mem[rd_base], w_mem[rd_base + AW'(1)],
                         w_mem[rd_base + AW'(2)], w_mem[rd_base + AW'(3)]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            nk_q         <= 4'd4;
            idx_q        <= '0;
            phase_q      <= '0;
            rcon_q       <= 8'h01;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rk_valid_q   <= 1'b0;
            num_rounds_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            nk_q         <= nk_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            rcon_q       <= rcon_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rk_valid_q   <= rk_valid_d;
            num_rounds_q <= num_rounds_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Word array has no reset; its contents are only visible through rk_valid.
    always_ff @(posedge clk) begin
        if (state_q == EXPAND) w_mem[idx_q] <= w_new;
        for (int unsigned j = 0; j < MAX_NK; j++) begin
            if (accept && j < 32'(nk_sel)) w_mem[AW'(j)] <= key_words[3'(7 - j)];
        end
    end

    assign bus.busy       = (state_q == EXPAND);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.num_rounds = num_rounds_q;
    assign bus.rk_rd_data = rd_data_q;
endmodule
